// File: rtl/mult_pkg.sv
// Shared types and helpers for the multicycle multiply/divide units.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int PROD_WIDTH = 2 * MULT_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } mult_state_t;

  // Two's-complement negate of the low 'width' bits; bits above 'width' are cleared.
  function automatic logic [PROD_WIDTH-1:0] twos_neg(input logic [PROD_WIDTH-1:0] value,
                                                     input int width);
    logic [PROD_WIDTH-1:0] mask;
    mask = (width >= PROD_WIDTH) ? '1 : ((PROD_WIDTH'(1) << width) - 1'b1);
    return (~value + 1'b1) & mask;
  endfunction

endpackage

// File: rtl/mult_seq.sv
// Shift-add sequential multiplier (MULT/MULTU), sharing the divider's start/busy/done handshake.
// Operands are reduced to magnitudes up front and the sign is applied once at the end.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  mult_state_t           state_q;
  logic [WIDTH-1:0]      mcand_q;
  logic [WIDTH-1:0]      mplier_q;
  logic [WIDTH-1:0]      acc_q;
  logic [WIDTH-1:0]      hi_q;
  logic [WIDTH-1:0]      lo_q;
  logic [CW-1:0]         count_q;
  logic                  neg_q;
  logic                  busy_q;
  logic                  done_q;

  logic [WIDTH-1:0]      absA_d;
  logic [WIDTH-1:0]      absB_d;
  logic [WIDTH:0]        sum_d;
  logic [PROD_WIDTH-1:0] prodRaw_d;
  logic [PROD_WIDTH-1:0] prodNeg_d;
  logic [2*WIDTH-1:0]    product_d;

  // The sum keeps one extra bit so the carry can shift into the accumulator MSB.
  always_comb begin
    absA_d    = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    absB_d    = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
    sum_d     = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    prodRaw_d = '0;
    prodRaw_d[2*WIDTH-1:0] = {acc_q, mplier_q};
    prodNeg_d = twos_neg(prodRaw_d, 2 * WIDTH);
    product_d = neg_q ? prodNeg_d[2*WIDTH-1:0] : {acc_q, mplier_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= absA_d;
            mplier_q <= absB_d;
            acc_q    <= '0;
            neg_q    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= sum_d[WIDTH:1];
          mplier_q <= {sum_d[0], mplier_q[WIDTH-1:1]};
          count_q  <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          {hi_q, lo_q} <= product_d;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
